ex_muldiv: RTL
==============

# ex_muldiv

Iterative multiply/divide unit in the EX stage, driven by the ID/EX pipeline register outputs (operand A/B, EX control bits). Executes MULT/MULTU/DIV/DIVU over a fixed 34-cycle sequence and owns the architectural HI/LO registers. It stalls the front of the pipeline only when a later instruction reads or writes HI/LO while an operation is still in flight. Results go to the EX/MEM path through the `hi`/`lo` outputs.

## Interface
- `clk`  in  1  pipeline clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  EX holds a MULT/MULTU/DIV/DIVU this cycle.
- `op`  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- `opa`  in  32  rs value (multiplicand / dividend).
- `opb`  in  32  rt value (multiplier / divisor).
- `hilo_rd`  in  1  EX holds an MFHI/MFLO.
- `wr_hi`  in  1  EX holds an MTHI.
- `wr_lo`  in  1  EX holds an MTLO.
- `wdata`  in  32  data for MTHI/MTLO.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.
- `busy`  out  1  operation in flight.
- `done`  out  1  one-cycle pulse: HI/LO just updated by an operation.
- `stall`  out  1  combinational; freezes PC, IF/ID and ID/EX, and bubbles EX/MEM.

## Operation
- States:
  - IDLE: waits for `start`.
  - CALC: 32 iterations, 5-bit counter from 31 down to 0.
  - FIX: sign correction and HI/LO write.
- IDLE → CALC on `start`.
  - Latches operand magnitudes: absolute value when op is signed and the macro is on, else raw.
  - Latches result-sign flags; clears the 64-bit working register.
- CALC, multiply: radix-2 shift-add, one multiplier bit per cycle, LSB first, 33-bit add.
- CALC, divide: restoring shift-subtract, one quotient bit per cycle, MSB first, 33-bit subtract.
- CALC → FIX when counter is 0 after its iteration.
- FIX → IDLE, and writes:
  - Multiply: HI = product[63:32], LO = product[31:0]. Negate the 64-bit product if the operand signs differ (signed only).
  - Divide: LO = quotient, HI = remainder. Negate the quotient if the signs differ. The remainder takes the sign of the dividend.
- Divide by zero: no trap. Result is LO = 0xFFFFFFFF, HI = dividend (raw `opa`). Full latency is still used.
- Signed DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- `stall` = `busy` & (`hilo_rd` | `wr_hi` | `wr_lo` | `start`). A new `start` while busy waits; it is never dropped.
- MTHI/MTLO in IDLE write the register at the next edge. They cannot coincide with FIX because they are stalled.
- `start` together with `wr_hi`/`wr_lo` in the same cycle is an illegal decode.

## Timing
- Reset (async, any state): state IDLE, counter 0.
  - `hi` = `lo` = 0, `busy` = 0, `done` = 0, `stall` = 0, working regs 0.
  - An in-flight operation is discarded.
- Edge 0 accepts `start` in IDLE. `busy` = 1 from edge 0 until edge 33.
- Edges 1–32 are CALC iterations. Edge 33 is FIX: it updates `hi`/`lo`, sets `done` = 1 for one cycle and sets `busy` = 0.
- Fixed latency: 33 edges from accept to result, independent of operand values and op.
- An MFHI stalled during busy sees new `hi`/`lo` in the cycle after edge 33, with `stall` = 0.
- A `start` held by stall is accepted at the edge after `busy` falls, i.e. back-to-back throughput of one op per 34 cycles.
- Reset deasserted with `start` = 1: accepted at the first edge after release.

## Configuration
- `MULDIV_SIGNED_EN` defined: MULT/DIV perform two's-complement abs/negate as above.
- Not defined:
  - `op[0]` is ignored; MULT ≡ MULTU and DIV ≡ DIVU.
  - Sign logic is removed.
  - FIX remains a pass-through cycle, so latency stays 33 edges.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI = 0xFFFFFFFE, LO = 0x00000001; `done` in the cycle after edge 33; `busy` low thereafter.
- MULT −3 (0xFFFFFFFD) × 5 → HI = 0xFFFFFFFF, LO = 0xFFFFFFF1 (macro on). With the macro off: HI = 0x00000004, LO = 0xFFFFFFF1.
- DIV −7 / 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIVU 100 / 0 → LO = 0xFFFFFFFF, HI = 0x00000064.
- MULTU 6 × 7 then `hilo_rd` = 1 at edge 5 → `stall` = 1 through edge 33, 0 after; LO = 42 visible when `stall` drops.
- MTLO 0x12345678 in IDLE → `lo` = 0x12345678 next edge, `stall` = 0. A second `start` issued during busy → `stall` = 1 and is accepted the edge after `done`.
- `rst_n` pulsed low at iteration 10 of DIVU 1000 / 3 → `hi` = `lo` = 0 and `busy` = `done` = 0 immediately. A fresh DIVU 1000 / 3 then gives LO = 333, HI = 1.

Source files
------------

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative 32x32 multiply / 32/32 divide unit with architectural HI/LO.
// Fixed 34-cycle sequence: accept, 32 iterations, one fix-up/write cycle.
// Optional feature macro: MULDIV_SIGNED_EN enables MULT/DIV sign handling.
module ex_muldiv (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] opa,
   input  logic [31:0] opb,
   input  logic        hilo_rd,
   input  logic        wr_hi,
   input  logic        wr_lo,
   input  logic [31:0] wdata,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        busy,
   output logic        done,
   output logic        stall
);

   localparam int unsigned XLEN  = 32;
   localparam int unsigned CNT_W = 5;

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   state_t            state, state_nx;
   logic [CNT_W-1:0]  cnt;
   logic              is_div;
   logic              neg_q, neg_r;
   logic [XLEN-1:0]   ma, mb;
   logic [2*XLEN-1:0] acc;

   logic [XLEN-1:0]   abs_a_c, abs_b_c;
   logic              neg_q_c, neg_r_c;
   logic [XLEN:0]     mul_sum_c, div_shift_c, div_diff_c;
   logic              q_bit_c;
   logic [2*XLEN-1:0] mul_res_c;
   logic [XLEN-1:0]   quo_c, rem_c;

`ifdef MULDIV_SIGNED_EN
   logic sa_c, sb_c;
   // Operand magnitudes and result-sign flags for signed ops
   assign sa_c    = op[0] & opa[XLEN-1];
   assign sb_c    = op[0] & opb[XLEN-1];
   assign abs_a_c = sa_c ? XLEN'(-opa) : opa;
   assign abs_b_c = sb_c ? XLEN'(-opb) : opb;
   // Divide by zero keeps the all-ones quotient regardless of dividend sign
   assign neg_q_c = (sa_c ^ sb_c) & (~op[1] | (opb != '0));
   assign neg_r_c = sa_c & op[1];
`else
   logic unused_op0;
   // Unsigned-only build: operands pass through raw
   assign abs_a_c    = opa;
   assign abs_b_c    = opb;
   assign neg_q_c    = 1'b0;
   assign neg_r_c    = 1'b0;
   assign unused_op0 = op[0];
`endif

   // Iteration datapath: shift-add for multiply, restoring subtract for divide
   assign mul_sum_c   = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (mb[0] ? ma : '0)};
   assign div_shift_c = {acc[2*XLEN-1:XLEN], ma[XLEN-1]};
   assign div_diff_c  = div_shift_c - {1'b0, mb};
   assign q_bit_c     = ~div_diff_c[XLEN];

   // Final sign correction
   assign mul_res_c = neg_q ? (2*XLEN)'(-acc) : acc;
   assign quo_c     = neg_q ? XLEN'(-acc[XLEN-1:0]) : acc[XLEN-1:0];
   assign rem_c     = neg_r ? XLEN'(-acc[2*XLEN-1:XLEN]) : acc[2*XLEN-1:XLEN];

   // Front-end hold while an HI/LO consumer or a new op meets a busy unit
   assign stall = busy & (hilo_rd | wr_hi | wr_lo | start);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // Next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = CALC;
         CALC:    if (cnt == '0) state_nx = FIX;
         FIX:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Operand latch, iteration counter and working register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt    <= '0;
         is_div <= 1'b0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         ma     <= '0;
         mb     <= '0;
         acc    <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               cnt    <= CNT_W'(XLEN - 1);
               is_div <= op[1];
               neg_q  <= neg_q_c;
               neg_r  <= neg_r_c;
               ma     <= abs_a_c;
               mb     <= abs_b_c;
               acc    <= '0;
            end
            CALC: begin
               if (cnt != '0) cnt <= cnt - CNT_W'(1);
               if (is_div) begin
                  acc <= {(q_bit_c ? div_diff_c[XLEN-1:0] : div_shift_c[XLEN-1:0]),
                          acc[XLEN-2:0], q_bit_c};
                  ma  <= {ma[XLEN-2:0], 1'b0};
               end else begin
                  acc <= {mul_sum_c, acc[XLEN-1:1]};
                  mb  <= {1'b0, mb[XLEN-1:1]};
               end
            end
            default: ;
         endcase
      end
   end

   // Architectural HI/LO plus busy/done flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi   <= '0;
         lo   <= '0;
         busy <= 1'b0;
         done <= 1'b0;
      end else begin
         busy <= (state_nx != IDLE);
         done <= (state == FIX);
         if (state == FIX) begin
            if (is_div) begin
               hi <= rem_c;
               lo <= quo_c;
            end else begin
               hi <= mul_res_c[2*XLEN-1:XLEN];
               lo <= mul_res_c[XLEN-1:0];
            end
         end else if (state == IDLE) begin
            if (wr_hi) hi <= wdata;
            if (wr_lo) lo <= wdata;
         end
      end
   end

endmodule
